// File: rtl/gfx_clk_pkg.sv
// Shared clocking definitions for the graphics clock/reset path: sequencer
// state encoding, default ratios and a counter-width helper.
package gfx_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    SER_UP    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int PIX_DIV            = 5;
  localparam int LOCK_STABLE_CYCLES = 1024;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow level signals entering the clk domain.
// Both stages reset to 0, so an asynchronous input reads as deasserted after reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Post-PLL reset sequencer: releases serializer then pixel-domain reset once lock
// is stable, and generates the 1-in-DIV pixel clock enable.
// Optional lock-loss counter: define PLL_RESET_SEQ_LOSS_CNT_EN.
module pll_reset_sequencer
  import gfx_clk_pkg::*;
#(
  parameter int DIV           = PIX_DIV,
  parameter int STABLE_CYCLES = LOCK_STABLE_CYCLES,
  parameter int SER_LEAD      = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_lock,
  output logic                  ser_rst,
  output logic                  pix_rst,
  output logic                  pix_en,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int DW = cnt_w(DIV);
  localparam int LW = cnt_w(SER_LEAD);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [LW-1:0] LEAD_LAST = LW'(SER_LEAD - 1);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

  seq_state_e    state_q, state_d;
  logic [SW-1:0] stab_q,  stab_d;
  logic [DW-1:0] div_q,   div_d;
  logic [LW-1:0] lead_q,  lead_d;
  logic [DW-1:0] div_next;
  logic          ser_rst_q, pix_rst_q, pix_en_q, ready_q;

  assign div_next = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    lead_d  = lead_q;
    div_d   = '0;
    case (state_q)
      WAIT_LOCK: begin
        stab_d = '0;
        lead_d = '0;
        if (lock_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == STAB_LAST) begin
          state_d = SER_UP;
          stab_d  = '0;
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      SER_UP: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          div_d = div_next;
          // RUN is entered on the strobe cycle so the divider restarts at 0
          // on the same edge that pix_rst deasserts.
          if (lead_q != LEAD_LAST) lead_d = lead_q + 1'b1;
          else if (div_q == DIV_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) state_d = WAIT_LOCK;
        else         div_d   = div_next;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_LOCK;
      stab_q    <= '0;
      div_q     <= '0;
      lead_q    <= '0;
      ser_rst_q <= 1'b1;
      pix_rst_q <= 1'b1;
      pix_en_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      div_q     <= div_d;
      lead_q    <= lead_d;
      ser_rst_q <= !(state_d == SER_UP || state_d == RUN);
      pix_rst_q <= (state_d != RUN);
      pix_en_q  <= (div_d == DIV_LAST);
      ready_q   <= (state_d == RUN);
    end
  end

  assign ser_rst = ser_rst_q;
  assign pix_rst = pix_rst_q;
  assign pix_en  = pix_en_q;
  assign ready   = ready_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q;
  logic                  loss_inc;

  assign loss_inc = (state_q == RUN) && !lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    loss_q <= '0;
    else if (loss_inc && ~&loss_q) loss_q <= loss_q + 1'b1;
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with DIV=5, STABLE_CYCLES=16, SER_LEAD=4.
// Lock-loss counter expectations follow PLL_RESET_SEQ_LOSS_CNT_EN.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

  localparam int LOSS_CNT_W = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  pll_lock = 1'b0;
  logic                  ser_rst, pix_rst, pix_en, ready;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pll_reset_sequencer #(
    .DIV(5), .STABLE_CYCLES(16), .SER_LEAD(4), .LOSS_CNT_W(LOSS_CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .ser_rst       (ser_rst),
    .pix_rst       (pix_rst),
    .pix_en        (pix_en),
    .ready         (ready),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_ser_rst"}, ser_rst, 1);
    chk({tag, "_pix_rst"}, pix_rst, 1);
    chk({tag, "_pix_en"},  pix_en,  0);
    chk({tag, "_ready"},   ready,   0);
  endtask

  function automatic logic [31:0] loss_exp(input int n);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  // Called just after lock (re)appears on the input; ends on the edge RUN is entered.
  task automatic check_relock(input string tag);
    tick(18);
    chk({tag, "_ser_hold"}, ser_rst, 1);
    tick(1);
    chk({tag, "_ser_rel"},  ser_rst, 0);
    chk({tag, "_pix_hold"}, pix_rst, 1);
    chk({tag, "_rdy_lo"},   ready,   0);
    tick(3);
    chk({tag, "_en_lo"},    pix_en,  0);
    tick(1);
    chk({tag, "_en_first"}, pix_en,  1);
    chk({tag, "_pix_hold2"}, pix_rst, 1);
    tick(1);
    chk({tag, "_pix_rel"},  pix_rst, 0);
    chk({tag, "_rdy_hi"},   ready,   1);
    chk({tag, "_en_off"},   pix_en,  0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    int losses;

    // 1: reset, then idle with no lock
    #12;
    chk_rst_vals("t1_in_rst");
    chk("t1_loss_in_rst", lock_loss_cnt, 0);
    rst_n = 1'b1;
    tick(50);
    chk_rst_vals("t1_idle");
    chk("t1_loss_idle", lock_loss_cnt, 0);

    // 3: one-cycle dropout at stab_cnt=10 restarts the full stability count
    pll_lock = 1'b1;
    tick(13);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    tick(5);
    chk("t3_no_early", ser_rst, 1);
    tick(13);
    chk("t3_ser_hold", ser_rst, 1);
    tick(1);
    chk("t3_ser_rel", ser_rst, 0);
    tick(5);
    chk("t3_pix_rel", pix_rst, 0);
    chk("t3_ready", ready, 1);
    chk("t3_loss", lock_loss_cnt, 0);

    // 4: three-cycle dropout in RUN
    tick(2);
    pll_lock = 1'b0;
    tick(2);
    chk("t4_ser_still", ser_rst, 0);
    chk("t4_rdy_still", ready, 1);
    tick(1);
    chk_rst_vals("t4_drop");
    chk("t4_loss", lock_loss_cnt, loss_exp(1));
    pll_lock = 1'b1;
    check_relock("t4");
    tick(4);
    chk("t4_en_p1", pix_en, 1);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      hits += int'(pix_en);
    end
    chk("t4_en_gap", hits, 0);
    tick(1);
    chk("t4_en_p2", pix_en, 1);

    // 5: repeated losses in RUN saturate the counter
    losses = 1;
    for (int i = 0; i < 300; i++) begin
      int n;
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      tick(2);
      losses++;
      n = 0;
      while (!ready && n < 60) begin
        tick(1);
        n++;
      end
      chk("t5_relock", ready, 1);
      if (losses == 100) chk("t5_loss_100", lock_loss_cnt, loss_exp(100));
      if (losses == 255) chk("t5_loss_255", lock_loss_cnt, loss_exp(255));
    end
    chk("t5_loss_sat", lock_loss_cnt, loss_exp(losses));

    // 6: async reset in RUN with div_cnt=3
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_rst_vals("t6_async");
    chk("t6_loss_clr", lock_loss_cnt, 0);
    #2;
    rst_n = 1'b1;
    check_relock("t6");
    chk("t6_loss", lock_loss_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
